// File: rtl/jt007232_romsrv.sv
// jt007232_romsrv
// Memory-side responder for the two PCM sample-fetch ports of jt007232.
// Each channel is served from a one-word cache. Misses fetch a 16-bit word
// over one shared memory handshake, and a round-robin arbiter picks the
// channel when both need memory.
//
// Build option: JT007232_PREFETCH_EN adds a next-word buffer per channel.
// That buffer is filled with cur_tag+1 whenever the bus is otherwise idle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cha_addr/cs/ok/dout   channel A byte port (ok/dout combinational)
//   chb_addr/cs/ok/dout   channel B byte port
//   mem_addr/cs           word request to memory, held until mem_ok
//   mem_ok/mem_data       acknowledge and little-endian data word
//
// Arbiter states:
//   state | meaning
//   IDLE  | no transaction outstanding, mem_cs low
//   REQ   | mem_cs high for mem_addr, waiting for mem_ok
module jt007232_romsrv #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cha_addr,
  input  logic          cha_cs,
  output logic          cha_ok,
  output logic [7:0]    cha_dout,
  input  logic [AW-1:0] chb_addr,
  input  logic          chb_cs,
  output logic          chb_ok,
  output logic [7:0]    chb_dout,
  output logic [AW-2:0] mem_addr,
  output logic          mem_cs,
  input  logic          mem_ok,
  input  logic [15:0]   mem_data
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr [2];
  logic [1:0]    cs;
  logic [1:0]    cur_v;
  logic [AW-2:0] cur_tag [2];
  logic [15:0]   cur_data [2];
  logic [1:0]    cur_hit, hit, miss;
  logic [15:0]   rd_data [2];
  logic [7:0]    dout [2];
  logic          gnt, rr;
  logic          start, start_ch;
  logic [AW-2:0] start_word;
`ifdef JT007232_PREFETCH_EN
  localparam logic [AW-2:0] ONE = {{(AW-2){1'b0}}, 1'b1};
  logic [1:0]    nxt_v, nxt_hit, promote, pf_req;
  logic [AW-2:0] nxt_tag [2];
  logic [15:0]   nxt_data [2];
  logic          pf, start_pf;
`endif

  assign addr[0] = cha_addr;
  assign addr[1] = chb_addr;
  assign cs      = {chb_cs, cha_cs};

  always_comb begin : lookup
    cur_hit = '0;
    hit     = '0;
    miss    = '0;
`ifdef JT007232_PREFETCH_EN
    nxt_hit = '0;
    promote = '0;
    pf_req  = '0;
`endif
    for (int i = 0; i < 2; i++) begin
      rd_data[i] = cur_data[i];
      dout[i]    = '0;
      cur_hit[i] = cs[i] && cur_v[i] && (cur_tag[i] == addr[i][AW-1:1]);
      hit[i]     = cur_hit[i];
`ifdef JT007232_PREFETCH_EN
      nxt_hit[i] = cs[i] && nxt_v[i] && (nxt_tag[i] == addr[i][AW-1:1]);
      // cur wins when both match; only a nxt-only match moves nxt into cur
      promote[i] = nxt_hit[i] && !cur_hit[i];
      if (promote[i]) rd_data[i] = nxt_data[i];
      hit[i]     = cur_hit[i] || nxt_hit[i];
      pf_req[i]  = cur_hit[i] && !(nxt_v[i] && (nxt_tag[i] == cur_tag[i] + ONE));
`endif
      miss[i] = cs[i] && !hit[i];
      if (hit[i]) dout[i] = addr[i][0] ? rd_data[i][15:8] : rd_data[i][7:0];
    end
  end

  assign cha_ok   = hit[0];
  assign chb_ok   = hit[1];
  assign cha_dout = dout[0];
  assign chb_dout = dout[1];

  always_comb begin : arb
    state_nxt  = state;
    start      = 1'b0;
    start_ch   = rr;
    start_word = mem_addr;
`ifdef JT007232_PREFETCH_EN
    start_pf   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|miss) begin
          start      = 1'b1;
          start_ch   = (&miss) ? rr : miss[1];
          start_word = addr[start_ch][AW-1:1];
          state_nxt  = REQ;
        end
`ifdef JT007232_PREFETCH_EN
        else if (|pf_req) begin
          start      = 1'b1;
          start_ch   = (&pf_req) ? rr : pf_req[1];
          start_word = cur_tag[start_ch] + ONE;
          start_pf   = 1'b1;
          state_nxt  = REQ;
        end
`endif
      end
      REQ:     if (mem_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      gnt      <= 1'b0;
      rr       <= 1'b0;
      cur_v    <= '0;
      for (int i = 0; i < 2; i++) begin
        cur_tag[i]  <= '0;
        cur_data[i] <= '0;
      end
`ifdef JT007232_PREFETCH_EN
      pf    <= 1'b0;
      nxt_v <= '0;
      for (int i = 0; i < 2; i++) begin
        nxt_tag[i]  <= '0;
        nxt_data[i] <= '0;
      end
`endif
    end else begin
      state <= state_nxt;
`ifdef JT007232_PREFETCH_EN
      for (int i = 0; i < 2; i++) begin
        if (promote[i]) begin
          cur_v[i]    <= 1'b1;
          cur_tag[i]  <= nxt_tag[i];
          cur_data[i] <= nxt_data[i];
          nxt_v[i]    <= 1'b0;
        end
      end
`endif
      if (start) begin
        gnt      <= start_ch;
        mem_cs   <= 1'b1;
        mem_addr <= start_word;
`ifdef JT007232_PREFETCH_EN
        pf       <= start_pf;
`endif
      end
      // mem_addr doubles as the latched word: it cannot move while in REQ
      if (state == REQ && mem_ok) begin
        mem_cs <= 1'b0;
        rr     <= ~gnt;
`ifdef JT007232_PREFETCH_EN
        if (pf) begin
          nxt_v[gnt]    <= 1'b1;
          nxt_tag[gnt]  <= mem_addr;
          nxt_data[gnt] <= mem_data;
        end else begin
          cur_v[gnt]    <= 1'b1;
          cur_tag[gnt]  <= mem_addr;
          cur_data[gnt] <= mem_data;
          nxt_v[gnt]    <= 1'b0;
        end
`else
        cur_v[gnt]    <= 1'b1;
        cur_tag[gnt]  <= mem_addr;
        cur_data[gnt] <= mem_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_jt007232_romsrv.sv
module tb_jt007232_romsrv;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr_in [2];
  logic [1:0]    cs_in;
  logic          cha_ok, chb_ok;
  logic [7:0]    cha_dout, chb_dout;
  logic [AW-2:0] mem_addr;
  logic          mem_cs, mem_ok;
  logic [15:0]   mem_data;

  int checks = 0;
  int failures = 0;
  int ntx;
  logic [15:0] txq [$];

  always #5 clk = ~clk;

  jt007232_romsrv #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cha_addr(addr_in[0]), .cha_cs(cs_in[0]), .cha_ok(cha_ok), .cha_dout(cha_dout),
    .chb_addr(addr_in[1]), .chb_cs(cs_in[1]), .chb_ok(chb_ok), .chb_dout(chb_dout),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_ok(mem_ok), .mem_data(mem_data)
  );

  // memory contents as a pure function of the word address
  function automatic logic [15:0] memf(input logic [15:0] w);
    return {w[7:0], w[15:8]} ^ 16'h3C96;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
    logic [15:0] w;
    w = memf(a[AW-1:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [31:0] r;
    if ($urandom_range(0, 7) == 0) r = $urandom;
    else r = $urandom_range(0, 47);
    return r[AW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one cycle with an immediately acknowledging memory
  task automatic tick_ack();
    mem_ok   = mem_cs;
    mem_data = memf(mem_addr);
    if (mem_cs) begin
      ntx++;
      txq.push_back(mem_addr);
    end
    tick();
    mem_ok = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cs_in = '0;
    addr_in[0] = '0;
    addr_in[1] = '0;
    mem_ok = 1'b0;
    mem_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({cha_ok, chb_ok} !== 2'b00) begin failures++; $display("FAIL rst_ok got=%b exp=00", {cha_ok, chb_ok}); end
    checks++;
    if ({cha_dout, chb_dout} !== 16'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0000", {cha_dout, chb_dout}); end
    checks++;
    if (mem_cs !== 1'b0 || mem_addr !== 16'h0) begin failures++; $display("FAIL rst_mem got cs=%b addr=%h exp cs=0 addr=0000", mem_cs, mem_addr); end
    rst_n = 1'b1;
    addr_in[0] = 17'h00010;
    cs_in = 2'b01;
    tick();
    checks++;
    if (mem_cs !== 1'b1) begin failures++; $display("FAIL rst_pre_req got cs=%b exp=1", mem_cs); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_cs !== 1'b0 || mem_addr !== 16'h0) begin failures++; $display("FAIL rst_mid_req got cs=%b addr=%h exp cs=0 addr=0000", mem_cs, mem_addr); end
    cs_in = 2'b00;
    tick();
    rst_n = 1'b1;
    mem_ok = 1'b1;
    mem_data = 16'h1234;
    tick();
    mem_ok = 1'b0;
    checks++;
    if (mem_cs !== 1'b0) begin failures++; $display("FAIL rst_late_ack got cs=%b exp=0", mem_cs); end
    cs_in = 2'b01;
    #1;
    checks++;
    if (cha_ok !== 1'b0) begin failures++; $display("FAIL rst_no_fill got ok=%b exp=0", cha_ok); end
    cs_in = 2'b00;
    tick();
  endtask

  task automatic test_fill();
    int seen;
    apply_reset();
    addr_in[0] = 17'h00010;
    cs_in = 2'b01;
    #1;
    checks++;
    if (cha_ok !== 1'b0 || cha_dout !== 8'h00) begin failures++; $display("FAIL fill_miss got ok=%b dout=%h exp ok=0 dout=00", cha_ok, cha_dout); end
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0008) begin failures++; $display("FAIL fill_req got cs=%b addr=%h exp cs=1 addr=0008", mem_cs, mem_addr); end
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0008) begin failures++; $display("FAIL fill_hold got cs=%b addr=%h exp cs=1 addr=0008", mem_cs, mem_addr); end
    mem_ok = 1'b1;
    mem_data = 16'hBEEF;
    tick();
    mem_ok = 1'b0;
    mem_data = 16'h0;
    checks++;
    if (mem_cs !== 1'b0 || cha_ok !== 1'b1 || cha_dout !== 8'hEF) begin
      failures++; $display("FAIL fill_done got cs=%b ok=%b dout=%h exp cs=0 ok=1 dout=ef", mem_cs, cha_ok, cha_dout);
    end
    addr_in[0] = 17'h00011;
    #1;
    checks++;
    if (cha_ok !== 1'b1 || cha_dout !== 8'hBE) begin failures++; $display("FAIL fill_hi got ok=%b dout=%h exp ok=1 dout=be", cha_ok, cha_dout); end
    seen = 0;
`ifdef JT007232_PREFETCH_EN
    cs_in = 2'b00;
`endif
    repeat (3) begin
      tick();
      if (mem_cs) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL fill_no_traffic got cycles=%0d exp=0", seen); end
    cs_in = 2'b00;
  endtask

  task automatic test_arb();
    apply_reset();
    addr_in[0] = 17'h00100;
    addr_in[1] = 17'h1FFFE;
    cs_in = 2'b11;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0080) begin failures++; $display("FAIL arb_first got cs=%b addr=%h exp cs=1 addr=0080", mem_cs, mem_addr); end
    mem_ok = 1'b1; mem_data = memf(16'h0080);
    tick();
    mem_ok = 1'b0;
    checks++;
    if (cha_ok !== 1'b1 || chb_ok !== 1'b0 || mem_cs !== 1'b0) begin
      failures++; $display("FAIL arb_a_done got oka=%b okb=%b cs=%b exp 1 0 0", cha_ok, chb_ok, mem_cs);
    end
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'hFFFF) begin failures++; $display("FAIL arb_second got cs=%b addr=%h exp cs=1 addr=ffff", mem_cs, mem_addr); end
    mem_ok = 1'b1; mem_data = memf(16'hFFFF);
    tick();
    mem_ok = 1'b0;
    checks++;
    if (chb_ok !== 1'b1 || chb_dout !== exp_byte(17'h1FFFE)) begin
      failures++; $display("FAIL arb_b_done got ok=%b dout=%h exp ok=1 dout=%h", chb_ok, chb_dout, exp_byte(17'h1FFFE));
    end
    cs_in = 2'b00;
    tick();
    // single A transaction leaves the pointer on B
    addr_in[0] = 17'h00300;
    cs_in = 2'b01;
    tick();
    mem_ok = 1'b1; mem_data = memf(mem_addr);
    tick();
    mem_ok = 1'b0;
    addr_in[0] = 17'h00400;
    addr_in[1] = 17'h00500;
    cs_in = 2'b11;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0280) begin failures++; $display("FAIL arb_rr_b got cs=%b addr=%h exp cs=1 addr=0280", mem_cs, mem_addr); end
    mem_ok = 1'b1; mem_data = memf(mem_addr);
    tick();
    mem_ok = 1'b0;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0200) begin failures++; $display("FAIL arb_rr_a got cs=%b addr=%h exp cs=1 addr=0200", mem_cs, mem_addr); end
    mem_ok = 1'b1; mem_data = memf(mem_addr);
    tick();
    mem_ok = 1'b0;
    checks++;
    if (cha_ok !== 1'b1 || chb_ok !== 1'b1 || cha_dout !== exp_byte(17'h00400) || chb_dout !== exp_byte(17'h00500)) begin
      failures++; $display("FAIL arb_rr_data got ok=%b%b a=%h b=%h exp ok=11 a=%h b=%h", cha_ok, chb_ok, cha_dout, chb_dout,
                           exp_byte(17'h00400), exp_byte(17'h00500));
    end
    cs_in = 2'b00;
    tick();
  endtask

  task automatic test_addr_change();
    apply_reset();
    addr_in[0] = 17'h00100;
    cs_in = 2'b01;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0080) begin failures++; $display("FAIL chg_req got cs=%b addr=%h exp cs=1 addr=0080", mem_cs, mem_addr); end
    addr_in[0] = 17'h00200;
    mem_ok = 1'b1; mem_data = 16'h1111;
    tick();
    mem_ok = 1'b0;
    checks++;
    if (cha_ok !== 1'b0 || mem_cs !== 1'b0) begin failures++; $display("FAIL chg_fill got ok=%b cs=%b exp ok=0 cs=0", cha_ok, mem_cs); end
    addr_in[0] = 17'h00100;
    #1;
    checks++;
    if (cha_ok !== 1'b1 || cha_dout !== 8'h11) begin failures++; $display("FAIL chg_tag got ok=%b dout=%h exp ok=1 dout=11", cha_ok, cha_dout); end
    addr_in[0] = 17'h00200;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0100) begin failures++; $display("FAIL chg_reissue got cs=%b addr=%h exp cs=1 addr=0100", mem_cs, mem_addr); end
    mem_ok = 1'b1; mem_data = memf(16'h0100);
    tick();
    mem_ok = 1'b0;
    checks++;
    if (cha_ok !== 1'b1 || cha_dout !== exp_byte(17'h00200)) begin
      failures++; $display("FAIL chg_done got ok=%b dout=%h exp ok=1 dout=%h", cha_ok, cha_dout, exp_byte(17'h00200));
    end
    cs_in = 2'b00;
    tick();
  endtask

  task automatic test_reuse();
    int exp_tx;
    apply_reset();
    ntx = 0;
    addr_in[1] = 17'h00020;
    cs_in = 2'b10;
    for (int i = 0; i < 10; i++) begin
      if (chb_ok) break;
      tick_ack();
    end
    checks++;
    if (chb_ok !== 1'b1 || chb_dout !== exp_byte(17'h00020)) begin
      failures++; $display("FAIL reuse_first got ok=%b dout=%h exp ok=1 dout=%h", chb_ok, chb_dout, exp_byte(17'h00020));
    end
    addr_in[1] = 17'h00021;
    #1;
    checks++;
    if (chb_ok !== 1'b1 || chb_dout !== exp_byte(17'h00021)) begin
      failures++; $display("FAIL reuse_hi got ok=%b dout=%h exp ok=1 dout=%h", chb_ok, chb_dout, exp_byte(17'h00021));
    end
    cs_in = 2'b00;
    tick_ack();
    tick_ack();
    addr_in[1] = 17'h00020;
    cs_in = 2'b10;
    #1;
    checks++;
    if (chb_ok !== 1'b1 || chb_dout !== exp_byte(17'h00020)) begin
      failures++; $display("FAIL reuse_again got ok=%b dout=%h exp ok=1 dout=%h", chb_ok, chb_dout, exp_byte(17'h00020));
    end
    addr_in[1] = 17'h00021;
    #1;
    checks++;
    if (chb_ok !== 1'b1 || chb_dout !== exp_byte(17'h00021)) begin
      failures++; $display("FAIL reuse_again_hi got ok=%b dout=%h exp ok=1 dout=%h", chb_ok, chb_dout, exp_byte(17'h00021));
    end
    repeat (3) tick_ack();
`ifdef JT007232_PREFETCH_EN
    exp_tx = 2;
`else
    exp_tx = 1;
`endif
    checks++;
    if (ntx != exp_tx) begin failures++; $display("FAIL reuse_tx_count got=%0d exp=%0d", ntx, exp_tx); end
    cs_in = 2'b00;
    tick();
  endtask

`ifdef JT007232_PREFETCH_EN
  task automatic test_prefetch();
    apply_reset();
    txq.delete();
    addr_in[0] = 17'h1FFFE;
    cs_in = 2'b01;
    for (int i = 0; i < 10; i++) begin
      if (cha_ok) break;
      tick_ack();
    end
    repeat (4) tick_ack();
    checks++;
    if (txq.size() < 2) begin failures++; $display("FAIL pf_count got=%0d exp>=2", txq.size()); end
    else if (txq[0] !== 16'hFFFF || txq[1] !== 16'h0000) begin
      failures++; $display("FAIL pf_addrs got=%h,%h exp=ffff,0000", txq[0], txq[1]);
    end
    addr_in[0] = 17'h00000;
    #1;
    checks++;
    if (cha_ok !== 1'b1 || cha_dout !== exp_byte(17'h00000)) begin
      failures++; $display("FAIL pf_hit got ok=%b dout=%h exp ok=1 dout=%h", cha_ok, cha_dout, exp_byte(17'h00000));
    end
    tick();
    checks++;
    if (mem_cs !== 1'b0 || cha_ok !== 1'b1) begin failures++; $display("FAIL pf_promote got cs=%b ok=%b exp cs=0 ok=1", mem_cs, cha_ok); end
    cs_in = 2'b00;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] ra [2];
    logic [1:0]    rc, okv;
    logic [7:0]    dv;
    logic [31:0]   r;
    int            pend [2];
    int            dly;
    logic          pcs, pok;
    logic [15:0]   paddr;
    apply_reset();
    rc = '0;
    ra[0] = '0; ra[1] = '0;
    pend[0] = 0; pend[1] = 0;
    dly = $urandom_range(0, 3);
    pcs = 1'b0; pok = 1'b0; paddr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pcs) begin
        checks++;
        if (pok) begin
          if (mem_cs !== 1'b0) begin failures++; $display("FAIL rnd_release cyc=%0d got cs=%b exp=0", cyc, mem_cs); end
        end else if (mem_cs !== 1'b1 || mem_addr !== paddr) begin
          failures++; $display("FAIL rnd_hold cyc=%0d got cs=%b addr=%h exp cs=1 addr=%h", cyc, mem_cs, mem_addr, paddr);
        end
      end
      okv = {chb_ok, cha_ok};
      for (int ch = 0; ch < 2; ch++) begin
        if (rc[ch] && okv[ch]) begin
          if ($urandom_range(0, 1) == 1) begin ra[ch] = rnd_addr(); pend[ch] = 0; end
        end else if (!rc[ch] && $urandom_range(0, 3) == 0) begin
          rc[ch] = 1'b1; ra[ch] = rnd_addr(); pend[ch] = 0;
        end
        if (rc[ch] && $urandom_range(0, 19) == 0) rc[ch] = 1'b0;
      end
      addr_in[0] = ra[0];
      addr_in[1] = ra[1];
      cs_in = rc;
      #1;
      okv = {chb_ok, cha_ok};
      for (int ch = 0; ch < 2; ch++) begin
        dv = (ch == 0) ? cha_dout : chb_dout;
        checks++;
        if (okv[ch]) begin
          pend[ch] = 0;
          if (!rc[ch] || dv !== exp_byte(ra[ch])) begin
            failures++; $display("FAIL rnd_data cyc=%0d ch=%0d cs=%b got=%h exp=%h", cyc, ch, rc[ch], dv, exp_byte(ra[ch]));
          end
        end else if (dv !== 8'h00) begin
          failures++; $display("FAIL rnd_dout_idle cyc=%0d ch=%0d got=%h exp=00", cyc, ch, dv);
        end else if (rc[ch]) begin
          pend[ch]++;
          if (pend[ch] > 40) begin
            failures++; $display("FAIL rnd_timeout cyc=%0d ch=%0d got pending=%0d exp<=40", cyc, ch, pend[ch]);
            pend[ch] = 0;
          end
        end
      end
      if (mem_cs) begin
        if (dly == 0) begin
          mem_ok = 1'b1;
          mem_data = memf(mem_addr);
          dly = $urandom_range(0, 3);
        end else begin
          mem_ok = 1'b0;
          dly--;
        end
      end else begin
        mem_ok = ($urandom_range(0, 3) == 0);
        r = $urandom;
        mem_data = r[15:0];
      end
      pcs = mem_cs; pok = mem_ok; paddr = mem_addr;
      tick();
    end
    cs_in = '0;
    mem_ok = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    cs_in = '0;
    addr_in[0] = '0;
    addr_in[1] = '0;
    mem_ok = 1'b0;
    mem_data = '0;
    ntx = 0;
    test_reset();
    test_fill();
    test_arb();
    test_addr_change();
    test_reuse();
`ifdef JT007232_PREFETCH_EN
    test_prefetch();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jt007232_romsrv.md
# jt007232_romsrv

Memory-side responder for the two PCM sample-fetch ports of the jt007232 sound block. It answers each channel's byte request (`addr`/`cs` in, `ok`/`dout` out) from a one-word cache per channel. Misses are served by fetching 16-bit words over a single shared external memory handshake, with round-robin arbitration. It sits between the jt007232 ROM ports and the SDRAM/BRAM controller, so both channels can share one physical memory slot.

## Interface
Parameters:
- `AW`, 17: channel byte-address width; the memory word address is `AW-1` bits.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cha_addr` in AW: channel A byte address.
- `cha_cs` in 1: channel A request.
- `cha_ok` out 1: channel A data valid for the current `cha_addr`.
- `cha_dout` out 8: channel A byte.
- `chb_addr`, `chb_cs`, `chb_ok`, `chb_dout`: same as channel A, for channel B.
- `mem_addr` out AW-1: word address to memory.
- `mem_cs` out 1: memory request, held until acknowledged.
- `mem_ok` in 1: memory acknowledge; `mem_data` is valid while this is high.
- `mem_data` in 16: memory word, little-endian (byte 0 in `[7:0]`).

## Operation
- Per channel X, the cache holds `curX_v`, `curX_tag[AW-2:0]` and `curX_data[15:0]`.
- Hit: `X_cs && curX_v && curX_tag==X_addr[AW-1:1]`.
- `X_ok = hit`. This is combinational from the cache registers and `X_addr`, with zero latency.
- `X_dout = X_addr[0] ? data[15:8] : data[7:0]`. It is 0 whenever `X_ok` is low.
- Miss: `X_cs && !hit`.
- The arbiter FSM has two states, IDLE and REQ.
- IDLE, no misses: stay in IDLE with `mem_cs=0`.
- IDLE, one miss: grant that channel. Latch `gnt` and `word=X_addr[AW-1:1]`, then on the next edge set `mem_cs=1`, `mem_addr=word` and go to REQ.
- IDLE, both miss: grant the channel selected by the `rr` pointer. `rr` resets to A.
- REQ: `mem_cs` and `mem_addr` stay constant until `mem_ok` is sampled high.
- On that edge, the granted cache gets `v=1`, `tag=word`, `data=mem_data`. At the same time `mem_cs` goes to 0, `rr` goes to the non-granted channel, and the FSM returns to IDLE.
- `mem_ok` is ignored in IDLE.
- A granted channel may drop `cs` or change `addr` while in REQ. The fetch still completes and fills under the latched `word`, with no abort. The new address then hits or misses normally.
- Cache entries persist while `cs` is low, so re-requesting the same word hits with no memory traffic.
- Reset, including mid-REQ: all `v` bits cleared, `mem_cs=0`, `mem_addr=0`, `rr`=A, FSM in IDLE. A `mem_ok` arriving after reset is ignored.

## Timing
- Reset values: `cha_ok=chb_ok=0`, `cha_dout=chb_dout=0`, `mem_cs=0`, `mem_addr=0`.
- Hit latency: 0 cycles.
- Miss latency: the miss is seen in IDLE at edge 0 and `mem_cs` rises at edge 1. If `mem_ok` is sampled at edge N (N≥1), the cache fills at N and `X_ok` is high after edge N.
- Minimum miss-to-ok latency is 1 edge, when `mem_ok` is already high at edge 1.
- `mem_cs` is low for at least one cycle between transactions.
- Worst-case service time for a miss: the pending other-channel transaction, plus 1 idle cycle, plus its own transaction.

## Configuration
- `JT007232_PREFETCH_EN` defined: each channel adds a next-word buffer `nxtX_v/tag/data`.
  - Hit becomes cur-match OR nxt-match.
  - A nxt-match makes `X_ok` high immediately, with data from nxt. On the next edge nxt is promoted to cur and nxt is invalidated.
  - Prefetch: in IDLE with no demand miss, fetch `curX_tag+1` into nxt for a channel that has `cs`, a cur hit, and nxt not already valid for `curX_tag+1`.
  - `curX_tag+1` wraps from all-ones to 0.
  - Demand misses always win arbitration over prefetches, and `rr` applies among prefetches too.
  - A demand fill invalidates that channel's nxt.
- `JT007232_PREFETCH_EN` undefined: no nxt buffers, no prefetch, and memory traffic is demand-only.

## Test plan
- Reset with `rst_n=0` mid-REQ (`mem_cs=1`), then release and pulse `mem_ok=1` → `mem_cs=0`, no cache fill, `cha_ok=0`.
- Channel A `addr=0x00010`, `cs=1`; memory returns `mem_data=0xBEEF` with `mem_ok` at edge 3 → `mem_addr=0x0008`, `cha_ok=1` after edge 3, `cha_dout=0xEF`. Then `addr=0x00011` → `cha_dout=0xBE` with no `mem_cs`.
- Both channels miss in the same cycle (A `0x00100`, B `0x1FFFE`) → A served first (`mem_addr=0x0080`), then one idle cycle, then B (`mem_addr=0xFFFF`). A second simultaneous miss → B served first.
- Channel A changes `addr` to `0x00200` while REQ for `0x00100` is pending → fill is tagged `0x0080`, `cha_ok=0`, and a new request is issued for `0x0100` after one idle cycle.
- Channel B reads `0x00020..0x00021` twice with `cs` toggled low between reads → only one memory transaction in total.
- `JT007232_PREFETCH_EN`: A reads `0x1FFFE` → fill `0xFFFF`, then prefetch `mem_addr=0x0000`. Moving `addr` to `0x00000` gives `cha_ok=1` in the same cycle, with no demand request.
